bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the multiplexed 8-digit display driver. It converts the two 8-bit operands A and B into three BCD digits each, using shift-and-add-3 (double dabble), one bit per clock. The display then only selects nibbles and no longer needs combinational /10 and %10 dividers. Results are held in output registers until the next conversion completes.

---
 rtl/bin2bcd_seq.sv | 161 ++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for operands A and B.
// bcdA/bcdB hold the last completed conversion; done pulses for the single cycle they update.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      numA,
    input  logic [WIDTH-1:0]      numB,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcdA,
    output logic [4*DIGITS-1:0]   bcdB,
    output logic                  valid,
    output logic [1:0]            o_dbg_state
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: start is a level request, sampled only while busy=0.
    // A request seen in IDLE is accepted on that edge; requests while busy are dropped.
    // done is a one-cycle pulse coinciding with the FINISH cycle; bcdA/bcdB are then valid.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_A = 2'd1,
        CONV_B = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // {scratch, shadow}: upper SW bits are the BCD scratch, lower WIDTH bits the operand being shifted out.
    logic [SW+WIDTH-1:0] r_sr;
    logic [WIDTH-1:0]    r_shadow_b;
    logic [SW-1:0]       r_res_a;
    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_bcd_a;
    logic [SW-1:0]       r_bcd_b;
    logic                r_done;
    logic                r_valid;

    logic [SW+WIDTH-1:0] w_sr_adj;
    logic [SW+WIDTH-1:0] w_sr_next;
    logic                w_last;

    // Add-3 correction on every scratch digit >= 5, all digits in parallel.
    always_comb begin
        w_sr_adj = r_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_sr[WIDTH+4*d +: 4] >= 4'd5) begin
                w_sr_adj[WIDTH+4*d +: 4] = r_sr[WIDTH+4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_sr_next = w_sr_adj << 1;
    assign w_last    = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = CONV_A;
                end
            end
            CONV_A: begin
                if (w_last) begin
                    w_next_state = CONV_B;
                end
            end
            CONV_B: begin
                if (w_last) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr       <= '0;
            r_shadow_b <= '0;
            r_res_a    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr       <= {{SW{1'b0}}, numA};
                        r_shadow_b <= numB;
                        r_cnt      <= CW'(WIDTH - 1);
                    end
                end
                CONV_A: begin
                    if (w_last) begin
                        r_res_a <= w_sr_next[SW+WIDTH-1:WIDTH];
                        r_sr    <= {{SW{1'b0}}, r_shadow_b};
                        r_cnt   <= CW'(WIDTH - 1);
                    end else begin
                        r_sr  <= w_sr_next;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                CONV_B: begin
                    r_sr <= w_sr_next;
                    if (!w_last) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Both results land on the FINISH-entry edge so the display never sees a half-updated pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd_a <= '0;
            r_bcd_b <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == CONV_B && w_last) begin
                r_bcd_a <= r_res_a;
                r_bcd_b <= w_sr_next[SW+WIDTH-1:WIDTH];
                r_done  <= 1'b1;
                r_valid <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign valid       = r_valid;
    assign bcdA        = r_bcd_a;
    assign bcdB        = r_bcd_b;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed scenarios plus a full sweep and random operand pairs,
// checked against an arithmetic decimal-digit model through a scoreboard queue.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int SW     = 4 * DIGITS;
    localparam int LAT    = 2 * WIDTH;      // edges after the capture edge until done is seen
    localparam int PERIOD = 2 * WIDTH + 2;  // cycles per conversion with start held high

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  numA;
    logic [WIDTH-1:0]  numB;
    logic              busy;
    logic              done;
    logic [SW-1:0]     bcdA;
    logic [SW-1:0]     bcdB;
    logic              valid;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*SW-1:0] exp_q[$];

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .numA        (numA),
        .numB        (numB),
        .busy        (busy),
        .done        (done),
        .bcdA        (bcdA),
        .bcdB        (bcdB),
        .valid       (valid),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [SW-1:0] to_bcd(input int n);
        int v;
        logic [SW-1:0] r;
        v = n;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) check_eq("idle_timeout", busy, 0);
    endtask

    // One conversion; pert_k>0 changes the operands that many edges after capture,
    // watch_a checks bcdA holds old_a every cycle until done.
    task automatic run_conv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int pert_k, input bit watch_a, input logic [SW-1:0] old_a);
        int k;
        bit got;
        logic [2*SW-1:0] exp;
        wait_idle();
        numA  = a;
        numB  = b;
        start = 1'b1;
        exp_q.push_back({to_bcd(int'(a)), to_bcd(int'(b))});
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (k == pert_k) begin
                numA = 8'd7;
                numB = 8'd200;
            end
            if (done) got = 1'b1;
            else if (watch_a) check_eq("bcdA_hold", bcdA, old_a);
        end
        check_eq("latency", k, LAT);
        exp = exp_q.pop_front();
        if (got) begin
            check_eq("bcdA", bcdA, exp[2*SW-1:SW]);
            check_eq("bcdB", bcdB, exp[SW-1:0]);
            check_eq("valid", valid, 1);
            check_eq("busy_in_finish", busy, 1);
            for (int d = 0; d < DIGITS; d++) begin
                check_eq("digitA_range", (bcdA[4*d +: 4] <= 4'd9), 1);
            end
            @(posedge clk);
            #1;
            check_eq("done_one_cycle", done, 0);
            check_eq("idle_after_finish", busy, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int dones;
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        numA  = '0;
        numB  = '0;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_bcdA", bcdA, 0);
        check_eq("rst_bcdB", bcdB, 0);
        check_eq("rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic conversion with boundary operands
        run_conv(8'd0, 8'd255, -1, 1'b0, '0);
        check_eq("t1_bcdB_255", bcdB, 12'h255);

        // 2: exhaustive sweep, then random pairs
        for (int n = 0; n < 256; n++) begin
            run_conv(8'(n), 8'(255 - n), -1, 1'b0, '0);
        end
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_conv(ra, rb, -1, 1'b0, '0);
        end

        // 3: operands changed mid-conversion are ignored
        run_conv(8'd128, 8'd99, 3, 1'b0, '0);
        check_eq("t3_bcdA", bcdA, 12'h128);

        // 4: start held high, one conversion every PERIOD cycles
        wait_idle();
        numA  = 8'd37;
        numB  = 8'd150;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 40; c++) begin
            cyc = (c + 1) % PERIOD;
            check_eq("t4_busy", busy, (cyc != 0));
            check_eq("t4_done", done, (cyc == PERIOD - 1));
            if (done) begin
                check_eq("t4_bcdA", bcdA, to_bcd(37));
                check_eq("t4_bcdB", bcdB, to_bcd(150));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // 5: asynchronous reset during a conversion
        run_conv(8'd42, 8'd17, -1, 1'b0, '0);
        wait_idle();
        numA  = 8'd123;
        numB  = 8'd45;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_done", done, 0);
        check_eq("t5_valid", valid, 0);
        check_eq("t5_bcdA", bcdA, 0);
        check_eq("t5_bcdB", bcdB, 0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check_eq("t5_no_done_after_rst", dones, 0);
        check_eq("t5_idle_after_rst", busy, 0);

        // 6: back-to-back results switch atomically
        run_conv(8'd5, 8'd0, -1, 1'b0, '0);
        run_conv(8'd250, 8'd1, -1, 1'b1, 12'h005);
        check_eq("t6_bcdA", bcdA, 12'h250);

        check_eq("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
